// File: rtl/simple_axi_pkg.sv
// Shared AXI constants, request structs and response resolution for the
// simple AXI master/slave pair.
package simple_axi_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int STRB_W = DATA_W / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] SIZE_1B = 3'b000;
    localparam logic [2:0] SIZE_2B = 3'b001;
    localparam logic [2:0] SIZE_4B = 3'b010;
    localparam logic [2:0] SIZE_8B = 3'b011;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [2:0]        size;
        logic [7:0]        len;
    } addr_req_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
        logic              last;
    } wdata_req_t;

    // Decode error beats protocol error; single-beat only, at most 8 bytes.
    function automatic logic [1:0] resolve_resp(input logic       in_range,
                                                input logic [7:0] len,
                                                input logic [2:0] size,
                                                input logic       last);
        if (!in_range)
            return RESP_DECERR;
        if (len != 8'd0 || size > SIZE_8B || !last)
            return RESP_SLVERR;
        return RESP_OKAY;
    endfunction

endpackage

// File: rtl/simple_axi_if.sv
// Single-beat AXI4 bus (no burst/cache/prot/lock/qos) between master and slave.
interface simple_axi_if;
    import simple_axi_pkg::*;

    logic              awvalid;
    logic              awready;
    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awsize;
    logic [7:0]        awlen;

    logic              wvalid;
    logic              wready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wlast;

    logic              bvalid;
    logic              bready;
    logic [1:0]        bresp;

    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arsize;
    logic [7:0]        arlen;

    logic              rvalid;
    logic              rready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;

    modport master (
        output awvalid, awaddr, awsize, awlen,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bresp,
        output bready,
        output arvalid, araddr, arsize, arlen,
        input  arready,
        input  rvalid, rdata, rresp, rlast,
        output rready
    );

    modport slave (
        input  awvalid, awaddr, awsize, awlen,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bresp,
        input  bready,
        input  arvalid, araddr, arsize, arlen,
        output arready,
        output rvalid, rdata, rresp, rlast,
        input  rready
    );

endinterface

// File: rtl/simple_axi_ram.sv
// DEPTH x 64-bit storage: one byte-enable write port, one asynchronous read
// port (the parent registers the read data). Contents are never reset.
module simple_axi_ram #(
    parameter  int DEPTH = 256,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] widx,
    input  logic [7:0]       wstrb,
    input  logic [63:0]      wdata,
    input  logic [IDX_W-1:0] ridx,
    output logic [63:0]      rdata
);

    logic [63:0] mem [DEPTH];

    // Byte-lane write; only strobed lanes change.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < 8; k++) begin
                if (wstrb[k])
                    mem[widx][k*8 +: 8] <= wdata[k*8 +: 8];
            end
        end
    end

    // Read sees pre-write contents on an edge that also writes the same word.
    assign rdata = mem[ridx];

endmodule

// File: rtl/simple_axi_slave.sv
// Single-beat AXI4 memory responder: address decode, response resolution,
// write capture/commit path and read FSM around a DEPTH x 64 RAM.
module simple_axi_slave
    import simple_axi_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter int          DEPTH     = 256
) (
    input logic          i_clk,
    input logic          i_rst,
    simple_axi_if.slave  s_axi
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [31:0] SPAN = 32'(DEPTH * 8);

    // ---------------- write path state ----------------
    addr_req_t  aw_q, aw_d;
    wdata_req_t w_q, w_d;
    logic       aw_held, aw_held_d, w_held, w_held_d;
    logic       awready_q, awready_d, wready_q, wready_d;
    logic       bvalid_q, bvalid_d;
    logic [1:0] bresp_q, bresp_d, wr_resp;
    logic       commit, ram_we;
    logic [31:0] aw_off;

    // ---------------- read path state ----------------
    r_state_t    r_state, r_state_d;
    logic        arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [63:0] rdata_q, rdata_d, ram_rdata;
    logic [1:0]  rresp_q, rresp_d, rd_resp;
    logic [31:0] ar_off;

    assign aw_off  = aw_q.addr - BASE_ADDR;
    assign wr_resp = resolve_resp(aw_off < SPAN, aw_q.len, aw_q.size, w_q.last);
    assign commit  = aw_held && w_held;

    assign ar_off  = s_axi.araddr - BASE_ADDR;
    assign rd_resp = resolve_resp(ar_off < SPAN, s_axi.arlen, s_axi.arsize, 1'b1);

    simple_axi_ram #(.DEPTH(DEPTH)) u_ram (
        .clk   (i_clk),
        .we    (ram_we),
        .widx  (aw_off[IDX_W+2:3]),
        .wstrb (w_q.strb),
        .wdata (w_q.data),
        .ridx  (ar_off[IDX_W+2:3]),
        .rdata (ram_rdata)
    );

    // Write next-state: capture AW/W independently, commit once both held.
    always_comb begin
        aw_held_d = aw_held;
        w_held_d  = w_held;
        aw_d      = aw_q;
        w_d       = w_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        ram_we    = 1'b0;
        if (commit) begin
            bvalid_d  = 1'b1;
            bresp_d   = wr_resp;
            ram_we    = (wr_resp == RESP_OKAY);
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
        end else begin
            if (s_axi.awvalid && awready_q) begin
                aw_held_d = 1'b1;
                aw_d      = '{addr: s_axi.awaddr, size: s_axi.awsize, len: s_axi.awlen};
            end
            if (s_axi.wvalid && wready_q) begin
                w_held_d = 1'b1;
                w_d      = '{data: s_axi.wdata, strb: s_axi.wstrb, last: s_axi.wlast};
            end
        end
        if (bvalid_q && s_axi.bready)
            bvalid_d = 1'b0;
        // Readies are registered copies of the post-edge capture state.
        awready_d = !aw_held_d && !bvalid_d;
        wready_d  = !w_held_d && !bvalid_d;
    end

    // Write path registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_q      <= '0;
            w_q       <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            aw_held   <= aw_held_d;
            w_held    <= w_held_d;
            aw_q      <= aw_d;
            w_q       <= w_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
        end
    end

    // Read FSM next-state: latch one response per AR, hold until rready.
    always_comb begin
        r_state_d = r_state;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (r_state)
            R_IDLE: begin
                arready_d = 1'b1;
                if (s_axi.arvalid && arready_q) begin
                    rdata_d   = (rd_resp == RESP_OKAY) ? ram_rdata : 64'h0;
                    rresp_d   = rd_resp;
                    rvalid_d  = 1'b1;
                    rlast_d   = 1'b1;
                    arready_d = 1'b0;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (s_axi.rready) begin
                    rvalid_d  = 1'b0;
                    rlast_d   = 1'b0;
                    arready_d = 1'b1;
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Read path registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            r_state   <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    assign s_axi.awready = awready_q;
    assign s_axi.wready  = wready_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.arready = arready_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = rresp_q;
    assign s_axi.rlast   = rlast_q;

endmodule
